// File: rtl/bcd_seven_seg_scan_pkg.sv
// Shared constants for the 4-digit seven-segment scan display: digit count,
// active-low glyph table and the BCD digit type.
package calc_disp_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [6:0] SEG_DASH   = 7'h3F;

    typedef logic [3:0] bcd_digit_t;

    // Segment order {g,f,e,d,c,b,a}. Non-BCD nibbles A..F show a dash.
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
    };

endpackage

// File: rtl/bcd_seven_seg_scan_if.sv
// Display-side bundle: BCD load port toward the display driver and the
// multiplexed common-anode segment/anode outputs.
interface bcd_seven_seg_scan_if;

    logic [15:0] bcd_in;
    logic        load;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        upd_done;

    modport master (
        output bcd_in, load,
        input  seg_n, an_n, upd_done
    );

    modport slave (
        input  bcd_in, load,
        output seg_n, an_n, upd_done
    );

endinterface

// File: rtl/bcd_seven_seg_scan_bcd_to_seg.sv
// Combinational BCD nibble to active-low seven-segment glyph lookup.
module bcd_to_seg
    import calc_disp_pkg::*;
(
    input  bcd_digit_t  i_digit,
    output logic [6:0]  o_seg_n
);

    assign o_seg_n = GLYPH[i_digit];

endmodule

// File: rtl/bcd_seven_seg_scan.sv
// 4-digit time-multiplexed common-anode display driver with frame-aligned commit
// of new BCD values. Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bcd_seven_seg_scan
    import calc_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_seven_seg_scan_if.slave   bus
);

    localparam int               PW         = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]    GUARD_LIM  = PW'(GUARD);
    localparam logic [1:0]       IDX_LAST   = 2'(NUM_DIGITS - 1);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [15:0]   r_pending;
    logic          r_pend_vld;
    logic [15:0]   r_shadow;
    logic [6:0]    r_seg_n;
    logic [3:0]    r_an_n;
    logic          r_upd_done;

    logic          w_wrap;
    logic          w_commit;
    bcd_digit_t    w_digit;
    logic [6:0]    w_glyph;
    logic          w_blank;
    logic [6:0]    w_seg_nxt;
    logic [3:0]    w_an_nxt;

    assign w_wrap   = (r_presc == PRESC_LAST);
    assign w_commit = w_wrap && (r_idx == IDX_LAST);
    assign w_digit  = r_shadow[{r_idx, 2'b00} +: 4];

    bcd_to_seg u_dec (
        .i_digit (w_digit),
        .o_seg_n (w_glyph)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] w_zero;
    logic [3:0] w_lead_blank;

    always_comb begin
        for (int k = 0; k < 4; k++) w_zero[k] = (r_shadow[4*k +: 4] == 4'h0);
        w_lead_blank[3] = w_zero[3];
        w_lead_blank[2] = w_zero[3] & w_zero[2];
        w_lead_blank[1] = w_zero[3] & w_zero[2] & w_zero[1];
        w_lead_blank[0] = 1'b0;
    end

    assign w_blank = w_lead_blank[r_idx];
`else
    assign w_blank = 1'b0;
`endif

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_seg_nxt = SEG_BLANK;
        w_an_nxt  = 4'hF;
        if (r_presc >= GUARD_LIM && !w_blank) begin
            w_an_nxt  = ~(4'b0001 << r_idx);
            w_seg_nxt = w_glyph;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= 2'd0;
        end else if (w_wrap) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // NOTE: the buffers are reset (not left as uninitialised storage) so the display reads 0000 after reset.
    // A load on the commit cycle wins pend_vld; the commit still takes the older pending value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= 16'h0000;
            r_pend_vld <= 1'b0;
            r_shadow   <= 16'h0000;
            r_upd_done <= 1'b0;
        end else begin
            if (bus.load) begin
                r_pending  <= bus.bcd_in;
                r_pend_vld <= 1'b1;
            end else if (w_commit) begin
                r_pend_vld <= 1'b0;
            end
            if (w_commit && r_pend_vld) r_shadow <= r_pending;
            r_upd_done <= w_commit && r_pend_vld;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_n <= SEG_BLANK;
            r_an_n  <= 4'hF;
        end else begin
            r_seg_n <= w_seg_nxt;
            r_an_n  <= w_an_nxt;
        end
    end

    assign bus.seg_n    = r_seg_n;
    assign bus.an_n     = r_an_n;
    assign bus.upd_done = r_upd_done;

endmodule
